dokmean_mul_mac_pipe: RTL and testbench
=======================================

Name: dokmean_mul_mac_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle doKmean multiplier primitive.
- Computes din0*din1 over NUM_STAGE registered stages (DSP48-inferable), with a selectable signed or unsigned mode.
- Adds a per-vector accumulator (first/last framing) for k-means squared-distance sums across dimensions, with saturation and an overflow flag.
- Sits between the point/centroid operand fetch and the nearest-centroid compare logic.

Parameters:
- ID, 1, instance tag; no functional effect.
- din0_WIDTH, 7, operand A width.
- din1_WIDTH, 10, operand B width.
- dout_WIDTH, 17, product width. Wider: sign/zero-extended per SIGNED. Narrower: low bits kept.
- NUM_STAGE, 3, product latency in ce-enabled cycles. Legal range 1..6.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands.
- ACC_WIDTH, 32, accumulator width. Must be >= dout_WIDTH.

Ports:
- clk  in  1  single clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable. 0 freezes all pipeline and accumulator state.
- in_valid  in  1  operand beat valid.
- in_first  in  1  beat is the first of a vector; qualified by in_valid.
- in_last  in  1  beat is the last of a vector; qualified by in_valid.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- dout  out  dout_WIDTH  registered product.
- dout_valid  out  1  dout holds a product of a valid beat.
- acc_out  out  ACC_WIDTH  completed vector sum.
- acc_valid  out  1  one-cycle pulse; acc_out valid.
- acc_ovf  out  1  the vector reported with acc_valid saturated.

Behaviour:
- Reset: synchronous, active-high, sampled on the clk rising edge; overrides ce. All valid/first/last pipe bits, dout, acc register, acc_out, acc_valid and acc_ovf clear to 0.
- Reset mid-operation: in-flight beats and any partial sum are discarded; no acc_valid is produced for them.
- Beat acceptance: a beat is taken on an edge where ce=1 and in_valid=1. There is no back-pressure; one beat per cycle is accepted.
- First/last framing:
  - in_first and in_last travel with the beat through the pipe.
  - in_first/in_last are ignored when in_valid=0.
- Product path:
  - Operands are registered at stage 1; the product is formed across stages; dout is the stage NUM_STAGE register.
  - dout_valid rises exactly NUM_STAGE ce-cycles after acceptance.
  - When ce=0, every stage holds, including dout and dout_valid.
  - Bubbles (in_valid=0) propagate as dout_valid=0. dout holds its last value during a bubble.
- Arithmetic:
  - SIGNED=0: unsigned full product of din0_WIDTH+din1_WIDTH bits.
  - SIGNED=1: signed full product of the same width.
  - The full product is then resized to dout_WIDTH as stated under Parameters.
- Accumulator (updates on an edge with ce=1 and dout_valid=1):
  - first=1: acc <= ext(dout); ovf <= 0.
  - first=0: acc <= sat(acc + ext(dout)); ovf <= ovf OR saturation on this add.
  - Saturation limits: unsigned saturates at 2^ACC_WIDTH-1. Signed clamps to max/min, with overflow detected from the sign bits.
  - Beat with last=1: on the following ce edge, acc_out takes the final sum and acc_ovf takes the final ovf. acc_valid pulses for exactly one ce-cycle.
  - A beat with first=1 and last=1 yields acc_out equal to that single product.
  - Back-to-back vectors are supported: a last beat may be immediately followed by a first beat with no gap.
- acc_valid deassertion: acc_valid clears on the next ce edge. With ce=0, acc_valid holds.
- Total latency: beat accepted to acc_valid = NUM_STAGE+1 ce-cycles.
- Framing errors:
  - A non-first beat arriving with no open vector accumulates onto the current acc (defined, not flagged).
  - A first beat arriving mid-vector restarts the sum.

Test Plan:
- Unsigned single beat, defaults: din0=127, din1=1023, first=last=1 at cycle 0 -> dout=129921 with dout_valid at cycle 3; acc_out=129921, acc_valid at cycle 4, acc_ovf=0.
- Signed, SIGNED=1, din1_WIDTH=10: din0=-64, din1=511 -> dout=-32704 (17'h18040).
- Vector sum, three beats (3,4), (5,6), (7,8) back-to-back with first on beat 1 and last on beat 3 -> single acc_valid pulse, acc_out=98; immediate next vector (2,2) with first=last=1 -> acc_out=4 on the next cycle.
- Saturation, ACC_WIDTH=18: three beats of 127*1023 -> acc_out=262143, acc_ovf=1; the next vector (1,1) -> acc_out=1, acc_ovf=0.
- ce stall: ce low for 5 cycles during the 3-beat sum -> all outputs frozen; result 98 arrives exactly 5 cycles late; no duplicated or lost acc_valid.
- Reset mid-vector: reset asserted after beat 2 of the 3-beat sum -> dout_valid, acc_valid, acc_out all 0; the next (2,3) single-beat vector -> acc_out=6.

Source files
------------

// File: rtl/dokmean_mul_mac_pipe.sv
// Pipelined din0*din1 multiplier with a framed, saturating per-vector accumulator.
// Latency: dout NUM_STAGE ce-cycles after beat acceptance; acc_out one ce-cycle later.
// No backpressure: one beat per ce-enabled cycle; ce=0 freezes every register.
module dokmean_mul_mac_pipe #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 7,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 17,
    parameter int NUM_STAGE  = 3,
    parameter int SIGNED     = 0,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  acc_valid,
    output logic                  acc_ovf
);

    // Full product width and the working width used for the resize step.
    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int XW = (PW > dout_WIDTH) ? PW : dout_WIDTH;
    localparam int AM = ACC_WIDTH - 1;

    localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    if (NUM_STAGE < 1 || NUM_STAGE > 6 || ACC_WIDTH < dout_WIDTH || ID < 0) begin : g_param_check
        $error("dokmean_mul_mac_pipe: illegal parameter set");
    end

    // Operands are extended to the full product width so that a plain modular
    // multiply yields the exact signed or unsigned product in its low PW bits.
    function automatic logic [dout_WIDTH-1:0] mul_resize(
        input logic [din0_WIDTH-1:0] a,
        input logic [din1_WIDTH-1:0] b
    );
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        logic [PW-1:0] p;
        logic [XW-1:0] px;
        if (SIGNED != 0) begin
            ax = PW'($signed(a));
            bx = PW'($signed(b));
        end else begin
            ax = PW'(a);
            bx = PW'(b);
        end
        p = ax * bx;
        if (SIGNED != 0) begin
            px = XW'($signed(p));
        end else begin
            px = XW'(p);
        end
        return px[dout_WIDTH-1:0];
    endfunction

    // ---------------------------------------------------------------
    // Control pipe: valid/first/last travel alongside the data stages.
    // Index 0 is stage 1; index NUM_STAGE-1 is the dout stage.
    // ---------------------------------------------------------------
    logic [NUM_STAGE-1:0] vld_q, vld_d;
    logic [NUM_STAGE-1:0] first_q, first_d;
    logic [NUM_STAGE-1:0] last_q, last_d;
    logic [dout_WIDTH-1:0] prod_out;

    // Shift the framing bits one stage per ce cycle; framing is masked by in_valid.
    always_comb begin
        vld_d   = vld_q;
        first_d = first_q;
        last_d  = last_q;
        if (ce) begin
            vld_d[0]   = in_valid;
            first_d[0] = in_valid & in_first;
            last_d[0]  = in_valid & in_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_d[i]   = vld_q[i-1];
                first_d[i] = first_q[i-1];
                last_d[i]  = last_q[i-1];
            end
        end
    end

    // Control pipe registers; reset empties the pipe so in-flight beats vanish.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            vld_q   <= vld_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    // ---------------------------------------------------------------
    // Data pipe. Each stage only loads when the beat feeding it is valid,
    // so dout keeps its last product across bubbles.
    // ---------------------------------------------------------------
    if (NUM_STAGE == 1) begin : g_one
        logic [dout_WIDTH-1:0] prod_q, prod_d;

        // Single stage: multiply straight from the ports into the output register.
        always_comb begin
            prod_d = prod_q;
            if (ce && in_valid) begin
                prod_d = mul_resize(din0, din1);
            end
        end

        // Output product register.
        always_ff @(posedge clk) begin
            if (reset) begin
                prod_q <= '0;
            end else begin
                prod_q <= prod_d;
            end
        end

        assign prod_out = prod_q;
    end else begin : g_multi
        logic [din0_WIDTH-1:0] opa_q, opa_d;
        logic [din1_WIDTH-1:0] opb_q, opb_d;
        logic [dout_WIDTH-1:0] pipe_q [2:NUM_STAGE];
        logic [dout_WIDTH-1:0] pipe_d [2:NUM_STAGE];

        // Stage 1 holds operands, stage 2 multiplies, later stages are retiming slack.
        always_comb begin
            opa_d  = opa_q;
            opb_d  = opb_q;
            pipe_d = pipe_q;
            if (ce) begin
                if (in_valid) begin
                    opa_d = din0;
                    opb_d = din1;
                end
                if (vld_q[0]) begin
                    pipe_d[2] = mul_resize(opa_q, opb_q);
                end
                for (int i = 3; i <= NUM_STAGE; i++) begin
                    if (vld_q[i-2]) begin
                        pipe_d[i] = pipe_q[i-1];
                    end
                end
            end
        end

        // Operand and product stage registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                opa_q  <= '0;
                opb_q  <= '0;
                pipe_q <= '{default: '0};
            end else begin
                opa_q  <= opa_d;
                opb_q  <= opb_d;
                pipe_q <= pipe_d;
            end
        end

        assign prod_out = pipe_q[NUM_STAGE];
    end

    // ---------------------------------------------------------------
    // Accumulator
    // ---------------------------------------------------------------
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
    logic                 acc_valid_q, acc_valid_d;
    logic                 acc_ovf_q, acc_ovf_d;
    logic [ACC_WIDTH-1:0] add_val;
    logic [ACC_WIDTH:0]   wide_sum;
    logic [ACC_WIDTH-1:0] sat_sum;
    logic                 sat_hit;

    // Extend the product to accumulator width and form the saturated running sum.
    always_comb begin
        if (SIGNED != 0) begin
            add_val = ACC_WIDTH'($signed(prod_out));
        end else begin
            add_val = ACC_WIDTH'(prod_out);
        end
        wide_sum = {1'b0, acc_q} + {1'b0, add_val};
        sat_sum  = wide_sum[ACC_WIDTH-1:0];
        sat_hit  = 1'b0;
        if (SIGNED != 0) begin
            // Same-sign operands producing an opposite-sign result is overflow.
            if ((acc_q[AM] == add_val[AM]) && (wide_sum[AM] != acc_q[AM])) begin
                sat_hit = 1'b1;
                sat_sum = acc_q[AM] ? SMIN : SMAX;
            end
        end else if (wide_sum[ACC_WIDTH]) begin
            sat_hit = 1'b1;
            sat_sum = '1;
        end
    end

    // Consume the dout-stage beat: restart on first, accumulate otherwise, report on last.
    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        acc_ovf_d   = acc_ovf_q;
        if (ce) begin
            acc_valid_d = 1'b0;
            if (vld_q[NUM_STAGE-1]) begin
                if (first_q[NUM_STAGE-1]) begin
                    acc_d = add_val;
                    ovf_d = 1'b0;
                end else begin
                    acc_d = sat_sum;
                    ovf_d = ovf_q | sat_hit;
                end
                if (last_q[NUM_STAGE-1]) begin
                    acc_valid_d = 1'b1;
                    acc_out_d   = acc_d;
                    acc_ovf_d   = ovf_d;
                end
            end
        end
    end

    // Accumulator and result registers; reset drops any partial sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            acc_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            acc_ovf_q   <= acc_ovf_d;
        end
    end

    assign dout       = prod_out;
    assign dout_valid = vld_q[NUM_STAGE-1];
    assign acc_out    = acc_out_q;
    assign acc_valid  = acc_valid_q;
    assign acc_ovf    = acc_ovf_q;

endmodule

// File: tb/tb_dokmean_mul_mac_pipe.sv
// Bench for dokmean_mul_mac_pipe: three instances (unsigned, signed, 18-bit accumulator)
// share one stimulus stream; table vectors, framing sequences and random traffic
// are compared against a beat-queue reference model every cycle.
module tb_dokmean_mul_mac_pipe;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       in_valid;
    logic       in_first;
    logic       in_last;
    logic [6:0] din0;
    logic [9:0] din1;

    logic [16:0] dout_def, dout_sgn, dout_sat;
    logic        dv_def, dv_sgn, dv_sat;
    logic [31:0] ao_def, ao_sgn;
    logic [17:0] ao_sat;
    logic        av_def, av_sgn, av_sat;
    logic        ov_def, ov_sgn, ov_sat;

    always #5 clk = ~clk;

    dokmean_mul_mac_pipe u_def (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .dout(dout_def), .dout_valid(dv_def),
        .acc_out(ao_def), .acc_valid(av_def), .acc_ovf(ov_def)
    );

    dokmean_mul_mac_pipe #(.SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .dout(dout_sgn), .dout_valid(dv_sgn),
        .acc_out(ao_sgn), .acc_valid(av_sgn), .acc_ovf(ov_sgn)
    );

    dokmean_mul_mac_pipe #(.ACC_WIDTH(18)) u_sat (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .din0(din0), .din1(din1), .dout(dout_sat), .dout_valid(dv_sat),
        .acc_out(ao_sat), .acc_valid(av_sat), .acc_ovf(ov_sat)
    );

    logic [16:0] dout_a [3];
    logic        dv_a   [3];
    logic [31:0] ao_a   [3];
    logic        av_a   [3];
    logic        ov_a   [3];

    assign dout_a[0] = dout_def;
    assign dout_a[1] = dout_sgn;
    assign dout_a[2] = dout_sat;
    assign dv_a[0]   = dv_def;
    assign dv_a[1]   = dv_sgn;
    assign dv_a[2]   = dv_sat;
    assign ao_a[0]   = ao_def;
    assign ao_a[1]   = ao_sgn;
    assign ao_a[2]   = {14'b0, ao_sat};
    assign av_a[0]   = av_def;
    assign av_a[1]   = av_sgn;
    assign av_a[2]   = av_sat;
    assign ov_a[0]   = ov_def;
    assign ov_a[1]   = ov_sgn;
    assign ov_a[2]   = ov_sat;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int e;
        int a;
        int b;
        bit f;
        bit l;
    } beat_t;

    beat_t  q[$];
    int     ce_cnt = 0;
    longint m_acc [3];
    bit     m_ovf [3];
    longint exp_dout [3];
    bit     exp_dv;
    bit     exp_av [3];
    longint exp_aout [3];
    bit     exp_aovf [3];

    function automatic int awid(input int k);
        return (k == 2) ? 18 : 32;
    endfunction

    // Numeric product; instance 1 treats operands as two's complement.
    function automatic longint prod(input int k, input int a, input int b);
        longint sa;
        longint sb;
        sa = a;
        sb = b;
        if (k == 1) begin
            if (a >= 64)  sa = a - 128;
            if (b >= 512) sb = b - 1024;
        end
        return sa * sb;
    endfunction

    function automatic longint mask(input longint v, input int w);
        return v & ((longint'(1) << w) - 1);
    endfunction

    // Apply current inputs for one clock edge, update the model, compare all outputs.
    task automatic step();
        bit     r, c, v, f, l;
        int     a, b;
        beat_t  bt;
        longint p, s, mx, mn;
        bit     ov;
        r = reset; c = ce; v = in_valid; f = in_first; l = in_last;
        a = int'(din0); b = int'(din1);
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            exp_dv = 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_acc[k] = 0; m_ovf[k] = 1'b0; exp_dout[k] = 0;
                exp_av[k] = 1'b0; exp_aout[k] = 0; exp_aovf[k] = 1'b0;
            end
        end else if (c) begin
            ce_cnt++;
            for (int k = 0; k < 3; k++) exp_av[k] = 1'b0;
            if (q.size() > 0 && q[0].e + N == ce_cnt) begin
                bt = q.pop_front();
                for (int k = 0; k < 3; k++) begin
                    p = prod(k, bt.a, bt.b);
                    if (bt.f) begin
                        m_acc[k] = p;
                        m_ovf[k] = 1'b0;
                    end else begin
                        s  = m_acc[k] + p;
                        ov = 1'b0;
                        if (k == 1) begin
                            mx = (longint'(1) << (awid(k) - 1)) - 1;
                            mn = -(longint'(1) << (awid(k) - 1));
                            if (s > mx) begin s = mx; ov = 1'b1; end
                            if (s < mn) begin s = mn; ov = 1'b1; end
                        end else begin
                            mx = (longint'(1) << awid(k)) - 1;
                            if (s > mx) begin s = mx; ov = 1'b1; end
                        end
                        m_acc[k] = s;
                        m_ovf[k] = m_ovf[k] | ov;
                    end
                    if (bt.l) begin
                        exp_av[k]   = 1'b1;
                        exp_aout[k] = m_acc[k];
                        exp_aovf[k] = m_ovf[k];
                    end
                end
            end
            if (v) q.push_back('{ce_cnt, a, b, f, l});
            exp_dv = (q.size() > 0) && (q[0].e + N - 1 == ce_cnt);
            if (exp_dv) begin
                for (int k = 0; k < 3; k++) exp_dout[k] = prod(k, q[0].a, q[0].b);
            end
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("m%0d_dout_valid", k), longint'(dv_a[k]), longint'(exp_dv));
            chk($sformatf("m%0d_dout", k), longint'(dout_a[k]), mask(exp_dout[k], 17));
            chk($sformatf("m%0d_acc_valid", k), longint'(av_a[k]), longint'(exp_av[k]));
            chk($sformatf("m%0d_acc_out", k), longint'(ao_a[k]), mask(exp_aout[k], awid(k)));
            chk($sformatf("m%0d_acc_ovf", k), longint'(ov_a[k]), longint'(exp_aovf[k]));
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    // ---------------- framed sequences ----------------
    int     sa [4];
    int     sb [4];
    bit     sf [4];
    bit     sl [4];
    int     pc [3];
    int     pcyc [3][2];
    longint pval [3][2];
    bit     povf [3][2];

    // Drive nb beats back-to-back (held during a ce stall) and log acc_valid pulses.
    task automatic run_seq(input int nb, input int stall_at, input int stall_len, input int ncyc);
        int bi;
        bi = 0;
        for (int k = 0; k < 3; k++) pc[k] = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            ce = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (bi < nb) begin
                in_valid = 1'b1; in_first = sf[bi]; in_last = sl[bi];
                din0 = 7'(sa[bi]); din1 = 10'(sb[bi]);
            end else begin
                idle();
            end
            step();
            if (ce && bi < nb) bi++;
            for (int k = 0; k < 3; k++) begin
                if (av_a[k]) begin
                    if (pc[k] < 2) begin
                        pcyc[k][pc[k]] = cyc;
                        pval[k][pc[k]] = longint'(ao_a[k]);
                        povf[k][pc[k]] = ov_a[k];
                    end
                    pc[k]++;
                end
            end
        end
        ce = 1'b1;
        idle();
    endtask

    typedef struct {
        int     a;
        int     b;
        longint exp_u;
        longint exp_s;
    } vec_t;

    vec_t tbl [7];
    int   cnt;

    initial begin
        tbl[0] = '{127, 1023, 129921, 1};
        tbl[1] = '{64,  511,  32704,  -32704};
        tbl[2] = '{0,   5,    0,      0};
        tbl[3] = '{1,   1,    1,      1};
        tbl[4] = '{64,  512,  32768,  32768};
        tbl[5] = '{100, 1000, 100000, 672};
        tbl[6] = '{127, 512,  65024,  512};

        reset = 1'b1; ce = 1'b1; din0 = '0; din1 = '0;
        idle();
        step();
        step();
        chk("reset_dout_valid", longint'(dv_def), 0);
        chk("reset_dout", longint'(dout_def), 0);
        chk("reset_acc_valid", longint'(av_def), 0);
        chk("reset_acc_out", longint'(ao_def), 0);
        chk("reset_acc_ovf", longint'(ov_def), 0);
        reset = 1'b0;
        step();

        // Single-beat vectors: dout after N cycles, acc_out one cycle later.
        for (int i = 0; i < 7; i++) begin
            din0 = 7'(tbl[i].a); din1 = 10'(tbl[i].b);
            in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
            step();
            idle();
            step();
            step();
            chk($sformatf("vec%0d_dout_valid", i), longint'(dv_def), 1);
            chk($sformatf("vec%0d_dout_u", i), longint'(dout_def), tbl[i].exp_u);
            chk($sformatf("vec%0d_dout_s", i), longint'(dout_sgn), mask(tbl[i].exp_s, 17));
            step();
            chk($sformatf("vec%0d_acc_valid", i), longint'(av_def), 1);
            chk($sformatf("vec%0d_acc_u", i), longint'(ao_def), tbl[i].exp_u);
            chk($sformatf("vec%0d_acc_s", i), longint'(ao_sgn), mask(tbl[i].exp_s, 32));
            chk($sformatf("vec%0d_acc_sat", i), longint'(ao_sat), tbl[i].exp_u);
            chk($sformatf("vec%0d_ovf", i), longint'(ov_def), 0);
            step();
            chk($sformatf("vec%0d_acc_valid_drop", i), longint'(av_def), 0);
        end

        // Three-beat sum followed immediately by a one-beat vector.
        sa = '{3, 5, 7, 2}; sb = '{4, 6, 8, 2}; sf = '{1, 0, 0, 1}; sl = '{0, 0, 1, 1};
        run_seq(4, 99, 0, 10);
        chk("sum_pulses", pc[0], 2);
        chk("sum_cycle", pcyc[0][0], 5);
        chk("sum_value", pval[0][0], 98);
        chk("b2b_cycle", pcyc[0][1], 6);
        chk("b2b_value", pval[0][1], 4);

        // Saturation in the 18-bit accumulator, then a clean vector.
        sa = '{127, 127, 127, 1}; sb = '{1023, 1023, 1023, 1};
        sf = '{1, 0, 0, 1}; sl = '{0, 0, 1, 1};
        run_seq(4, 99, 0, 10);
        chk("sat_value", pval[2][0], 262143);
        chk("sat_ovf", longint'(povf[2][0]), 1);
        chk("sat_next_value", pval[2][1], 1);
        chk("sat_next_ovf", longint'(povf[2][1]), 0);
        chk("wide_value", pval[0][0], 389763);
        chk("wide_ovf", longint'(povf[0][0]), 0);

        // ce stall of 5 cycles in the middle of the sum.
        sa = '{3, 5, 7, 0}; sb = '{4, 6, 8, 0}; sf = '{1, 0, 0, 0}; sl = '{0, 0, 1, 0};
        run_seq(3, 2, 5, 16);
        chk("stall_pulses", pc[0], 1);
        chk("stall_cycle", pcyc[0][0], 10);
        chk("stall_value", pval[0][0], 98);

        // Reset after beat 2 discards the partial sum.
        din0 = 7'd3; din1 = 10'd4; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b0;
        step();
        din0 = 7'd5; din1 = 10'd6; in_first = 1'b0;
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_mid_dout_valid", longint'(dv_def), 0);
        chk("rst_mid_acc_valid", longint'(av_def), 0);
        chk("rst_mid_acc_out", longint'(ao_def), 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (av_def || dv_def) cnt++;
        end
        chk("rst_mid_no_output", cnt, 0);
        sa = '{2, 0, 0, 0}; sb = '{3, 0, 0, 0}; sf = '{1, 0, 0, 0}; sl = '{1, 0, 0, 0};
        run_seq(1, 99, 0, 6);
        chk("rst_next_pulses", pc[0], 1);
        chk("rst_next_value", pval[0][0], 6);

        // Random traffic with ce gaps, bubbles, loose framing and rare resets.
        for (int i = 0; i < 800; i++) begin
            ce       = ($urandom_range(0, 9) < 8);
            reset    = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 9) < 7);
            in_first = ($urandom_range(0, 9) < 3);
            in_last  = ($urandom_range(0, 9) < 3);
            din0     = 7'($urandom);
            din1     = 10'($urandom);
            step();
        end
        reset = 1'b0; ce = 1'b1;
        idle();
        for (int i = 0; i < 6; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
